// File: rtl/d_cache_loader.sv
// d_cache preload/dump initiator: packs a byte stream into words and writes
// them to the d_cache, or reads words back and streams them out as bytes.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   start_load, start_dump       one-cycle command pulses (load wins a tie)
//   len_words                    word count, sampled on the accepted start
//   s_data/s_valid/s_ready       input byte stream
//   m_data/m_valid/m_ready       output byte stream
//   data_en/input_addr/input_data  d_cache preload write port
//   dump_addr/output_check       d_cache readback address and word
//   core_hold                    high whenever not idle
//   done                         one-cycle pulse ending each accepted command
//   err                          sticky length error, cleared on next start
module d_cache_loader #(
  parameter int Depth    = 120,
  parameter int BaseAddr = 0,
  parameter int DPW      = 32,
  parameter int CntW     = $clog2(Depth/4+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_load,
  input  logic            start_dump,
  input  logic [CntW-1:0] len_words,
  input  logic [7:0]      s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [7:0]      m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            data_en,
  output logic [DPW-1:0]  input_addr,
  output logic [DPW-1:0]  input_data,
  output logic [DPW-1:0]  dump_addr,
  input  logic [DPW-1:0]  output_check,
  output logic            core_hold,
  output logic            done,
  output logic            err
);

  localparam int MaxW = Depth/4;

  typedef enum logic [2:0] {
    IDLE, LD_BYTE, LD_WR, DP_ADDR, DP_CAP, DP_SEND, FIN
  } state_t;

  state_t          state;
  logic [CntW-1:0] len;
  logic [CntW-1:0] k;
  logic [CntW-1:0] k_nx;
  logic [1:0]      b;
  // Low three bytes of the word being packed, newest byte on top.
  logic [23:0]     word;
  // Bytes still to send after the one on m_data, next byte at the bottom.
  logic [23:0]     sh;

  assign k_nx = k + CntW'(1);

  function automatic logic [DPW-1:0] waddr(input logic [CntW-1:0] idx);
    return DPW'(BaseAddr) + (DPW'(idx) << 2);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      k          <= '0;
      b          <= '0;
      word       <= '0;
      sh         <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      data_en    <= 1'b0;
      input_addr <= '0;
      input_data <= '0;
      dump_addr  <= '0;
      core_hold  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      data_en <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_load || start_dump) begin
            err       <= 1'b0;
            len       <= len_words;
            k         <= '0;
            b         <= '0;
            core_hold <= 1'b1;
            if (len_words == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (len_words > CntW'(MaxW)) begin
              err   <= 1'b1;
              state <= FIN;
              done  <= 1'b1;
            end else if (start_load) begin
              state   <= LD_BYTE;
              s_ready <= 1'b1;
            end else begin
              state     <= DP_ADDR;
              dump_addr <= waddr('0);
            end
          end
        end
        LD_BYTE: begin
          if (s_valid) begin
            b    <= b + 2'd1;
            word <= {s_data, word[23:8]};
            if (b == 2'd3) begin
              s_ready    <= 1'b0;
              data_en    <= 1'b1;
              input_addr <= waddr(k);
              input_data <= DPW'({s_data, word});
              state      <= LD_WR;
            end
          end
        end
        LD_WR: begin
          k <= k_nx;
          if (k_nx == len) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state   <= LD_BYTE;
            s_ready <= 1'b1;
          end
        end
        DP_ADDR: state <= DP_CAP;
        DP_CAP: begin
          // output_check reflects dump_addr from the DP_ADDR edge.
          m_data  <= output_check[7:0];
          sh      <= output_check[31:8];
          m_valid <= 1'b1;
          b       <= '0;
          state   <= DP_SEND;
        end
        DP_SEND: begin
          if (m_ready) begin
            b      <= b + 2'd1;
            m_data <= sh[7:0];
            sh     <= {8'h00, sh[23:8]};
            if (b == 2'd3) begin
              m_valid <= 1'b0;
              k       <= k_nx;
              if (k_nx == len) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                state     <= DP_ADDR;
                dump_addr <= waddr(k_nx);
              end
            end
          end
        end
        FIN: begin
          core_hold <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
